// File: rtl/vj_eval_pkg.sv
// Shared types and helpers for the cascade stage evaluator: FSM states,
// node word layout, node record and the saturating accumulator add.
package vj_eval_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_e;

    localparam int NODE_FIELD_W   = 16;
    localparam int NODE_THR_LSB   = 32;
    localparam int NODE_LEFT_LSB  = 16;
    localparam int NODE_RIGHT_LSB = 0;

    typedef struct packed {
        logic signed [NODE_FIELD_W-1:0] thr;
        logic signed [NODE_FIELD_W-1:0] left;
        logic signed [NODE_FIELD_W-1:0] right;
    } node_t;

    // Adds two sign-extended operands and clamps to a signed range of 'width' bits.
    function automatic logic signed [63:0] sat_add(input logic signed [63:0] a,
                                                   input logic signed [63:0] b,
                                                   input int width);
        logic signed [63:0] sum;
        logic signed [63:0] maxv;
        logic signed [63:0] minv;
        sum  = a + b;
        maxv = (64'sd1 <<< (width - 1)) - 64'sd1;
        minv = -(64'sd1 <<< (width - 1));
        if (sum > maxv) begin
            return maxv;
        end else if (sum < minv) begin
            return minv;
        end
        return sum;
    endfunction

endpackage

// File: rtl/node_fifo.sv
// Synchronous FIFO of decoded node records; head is read from registered
// storage, so a pushed node becomes visible one cycle after the push.
module node_fifo
    import vj_eval_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     flush_i,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  node_t                    node_i,
    output node_t                    head_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     empty_o,
    output logic                     full_o
);

    localparam int AW = $clog2(DEPTH);

    node_t             r_mem [DEPTH];
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [AW:0]       r_count;
    logic              w_do_push;
    logic              w_do_pop;

    assign empty_o = (r_count == '0);
    assign full_o  = (r_count == (AW+1)'(DEPTH));
    assign count_o = r_count;
    assign head_o  = r_mem[r_rd_ptr];

    // A push into a full buffer is dropped unless a pop frees a slot this cycle.
    assign w_do_pop  = pop_i && !empty_o;
    assign w_do_push = push_i && (!full_o || w_do_pop);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_do_push && !flush_i) begin
            r_mem[r_wr_ptr] <= node_i;
        end
    end

endmodule

// File: rtl/stage_evaluator.sv
// Responder end of the cascade ROM sequencer: buffers node words, scores
// in-order features into a per-stage sum and decides pass/fail per stage.
module stage_evaluator
    import vj_eval_pkg::*;
#(
    parameter int DATA_W     = 48,
    parameter int THR_W      = 16,
    parameter int LEAF_W     = 16,
    parameter int ACC_W      = 24,
    parameter int FIFO_DEPTH = 4,
    parameter int ROM_LAT    = 1,
    parameter int STAGE_W    = 5
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    start_i,
    input  logic                    rom_val_i,
    input  logic [DATA_W-1:0]       rom_data_i,
    input  logic                    stage_val_i,
    input  logic                    stage_last_i,
    input  logic                    feat_val_i,
    input  logic signed [THR_W-1:0] feat_i,
    output logic                    wait_o,
    output logic                    next_stage_o,
    output logic                    break_o,
    output logic                    done_o,
    output logic                    face_o,
    output logic [STAGE_W-1:0]      stage_idx_o,
    output logic                    err_o
);

    localparam int CW    = $clog2(FIFO_DEPTH) + 1;
    localparam int OCC_W = CW + 1;

    state_e                    r_state;
    state_e                    w_next_state;
    logic [ROM_LAT-1:0]        r_inflight;
    logic signed [ACC_W-1:0]   r_acc;
    logic                      r_next_stage;
    logic                      r_break;
    logic                      r_done;
    logic                      r_face;
    logic                      r_err;
    logic [STAGE_W-1:0]        r_stage_idx;

    node_t                     w_node_in;
    node_t                     w_fifo_head;
    node_t                     w_head;
    logic [CW-1:0]             w_fifo_count;
    logic                      w_fifo_empty;
    logic                      w_fifo_full;
    logic                      w_push_strobe;
    logic                      w_bypass;
    logic                      w_push;
    logic                      w_pop;
    logic                      w_consume;
    logic                      w_flush;
    logic signed [LEAF_W-1:0]  w_leaf;
    logic signed [ACC_W-1:0]   w_stage_thr;
    logic                      w_pass;
    logic                      w_decide_ok;
    logic                      w_start;
    logic                      w_fire_next;
    logic                      w_fire_break;
    logic [OCC_W-1:0]          w_occ;
    logic                      w_err_under;
    logic                      w_err_over;
    logic                      w_err_rom;

    assign w_node_in.thr   = rom_data_i[NODE_THR_LSB   +: NODE_FIELD_W];
    assign w_node_in.left  = rom_data_i[NODE_LEFT_LSB  +: NODE_FIELD_W];
    assign w_node_in.right = rom_data_i[NODE_RIGHT_LSB +: NODE_FIELD_W];

    // A feature arriving on an empty buffer takes the node landing this cycle directly.
    assign w_push_strobe = r_inflight[ROM_LAT-1];
    assign w_bypass      = feat_val_i && w_fifo_empty && w_push_strobe;
    assign w_push        = w_push_strobe && !w_bypass;
    assign w_pop         = feat_val_i && !w_fifo_empty;
    assign w_consume     = feat_val_i && (!w_fifo_empty || w_push_strobe);
    assign w_head        = w_bypass ? w_node_in : w_fifo_head;
    assign w_leaf        = (feat_i < w_head.thr) ? w_head.left : w_head.right;
    assign w_flush       = w_fire_break || r_break;

    assign w_stage_thr = rom_data_i[ACC_W-1:0];
    assign w_pass      = (r_acc >= w_stage_thr);
    assign w_decide_ok = stage_val_i && w_fifo_empty && (r_inflight == '0) && !feat_val_i;

    assign w_occ = OCC_W'(w_fifo_count) + OCC_W'($countones(r_inflight));

    assign w_err_under = feat_val_i && w_fifo_empty && !w_push_strobe;
    assign w_err_over  = w_push && w_fifo_full && !w_pop;
    assign w_err_rom   = rom_val_i && stage_val_i;

    node_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_node_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .flush_i (w_flush),
        .push_i  (w_push),
        .pop_i   (w_pop),
        .node_i  (w_node_in),
        .head_o  (w_fifo_head),
        .count_o (w_fifo_count),
        .empty_o (w_fifo_empty),
        .full_o  (w_fifo_full)
    );

    // HOLD spends one cycle after a pass so the still-high stage_val_i is not re-judged.
    always_comb begin
        w_next_state = r_state;
        w_start      = 1'b0;
        w_fire_next  = 1'b0;
        w_fire_break = 1'b0;
        case (r_state)
            IDLE: begin
                if (start_i) begin
                    w_start      = 1'b1;
                    w_next_state = RUN;
                end
            end
            RUN: begin
                if (w_decide_ok) begin
                    if (w_pass && !stage_last_i) begin
                        w_fire_next  = 1'b1;
                        w_next_state = HOLD;
                    end else begin
                        w_fire_break = 1'b1;
                        w_next_state = IDLE;
                    end
                end
            end
            HOLD: begin
                w_next_state = RUN;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state      <= IDLE;
            r_inflight   <= '0;
            r_acc        <= '0;
            r_next_stage <= 1'b0;
            r_break      <= 1'b0;
            r_done       <= 1'b0;
            r_face       <= 1'b0;
            r_err        <= 1'b0;
            r_stage_idx  <= '0;
        end else begin
            r_state      <= w_next_state;
            r_next_stage <= w_fire_next;
            r_break      <= w_fire_break;
            r_done       <= w_fire_break;
            r_err        <= r_err | w_err_under | w_err_over | w_err_rom;

            if (w_flush) begin
                r_inflight <= '0;
            end else begin
                r_inflight <= ROM_LAT'({r_inflight, rom_val_i});
            end

            if (w_start || w_fire_next) begin
                r_acc <= '0;
            end else if (w_consume) begin
                r_acc <= ACC_W'(sat_add(64'(r_acc), 64'(w_leaf), ACC_W));
            end

            if (w_start) begin
                r_stage_idx <= '0;
                r_face      <= 1'b0;
            end else if (w_fire_next) begin
                r_stage_idx <= r_stage_idx + 1'b1;
            end else if (w_fire_break) begin
                r_face <= w_pass && stage_last_i;
            end
        end
    end

    assign wait_o       = (r_state == IDLE) || (w_occ >= OCC_W'(FIFO_DEPTH - 2));
    assign next_stage_o = r_next_stage;
    assign break_o      = r_break;
    assign done_o       = r_done;
    assign face_o       = r_face;
    assign stage_idx_o  = r_stage_idx;
    assign err_o        = r_err;

endmodule

// File: tb/tb_stage_evaluator.sv
// Directed bench for stage_evaluator: acts as ROM sequencer and feature unit,
// checking stage pass/fail, final decision, backpressure, saturation and errors.
module tb_stage_evaluator;

    logic               clk = 1'b0;
    logic               rst;
    logic               startIn;
    logic               romVal;
    logic [47:0]        romData;
    logic               stageVal;
    logic               stageLast;
    logic               featVal;
    logic signed [15:0] featIn;

    logic               waitOut, nextStage, breakOut, doneOut, faceOut, errOut;
    logic [4:0]         stageIdx;
    logic               waitOut16, nextStage16, breakOut16, doneOut16, faceOut16, errOut16;
    logic [4:0]         stageIdx16;

    int total = 0;
    int bad   = 0;

    // Node with thr=0, left=-5, right=+10.
    localparam logic [47:0] NODE_A = 48'h0000_FFFB_000A;

    always #5 clk = ~clk;

    stage_evaluator dut (
        .clk_i(clk), .rst_i(rst), .start_i(startIn), .rom_val_i(romVal),
        .rom_data_i(romData), .stage_val_i(stageVal), .stage_last_i(stageLast),
        .feat_val_i(featVal), .feat_i(featIn), .wait_o(waitOut),
        .next_stage_o(nextStage), .break_o(breakOut), .done_o(doneOut),
        .face_o(faceOut), .stage_idx_o(stageIdx), .err_o(errOut)
    );

    // Narrow accumulator copy, used to expose saturation at the 16-bit limit.
    stage_evaluator #(.ACC_W(16)) dut16 (
        .clk_i(clk), .rst_i(rst), .start_i(startIn), .rom_val_i(romVal),
        .rom_data_i(romData), .stage_val_i(stageVal), .stage_last_i(stageLast),
        .feat_val_i(featVal), .feat_i(featIn), .wait_o(waitOut16),
        .next_stage_o(nextStage16), .break_o(breakOut16), .done_o(doneOut16),
        .face_o(faceOut16), .stage_idx_o(stageIdx16), .err_o(errOut16)
    );

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic pulse_start();
        startIn = 1'b1;
        tick();
        startIn = 1'b0;
    endtask

    task automatic send_node(input logic [47:0] w);
        romVal = 1'b1;
        tick();
        romVal  = 1'b0;
        romData = w;
        tick();
    endtask

    task automatic send_feat(input logic signed [15:0] f);
        featVal = 1'b1;
        featIn  = f;
        tick();
        featVal = 1'b0;
    endtask

    // Three NODE_A nodes scored with features 1, -1, 2: 10 - 5 + 10 = 15.
    task automatic load_stage_a();
        for (int i = 0; i < 3; i++) send_node(NODE_A);
        send_feat(16'sd1);
        send_feat(-16'sd1);
        send_feat(16'sd2);
    endtask

    // Parks on the stage word until a decision pulse appears (bounded).
    task automatic run_stage(input logic [23:0] thr, input logic last,
                             output logic sawNext, output logic sawBreak,
                             output logic sawDone, output logic face,
                             output logic [4:0] idx, output int cyc);
        stageVal  = 1'b1;
        stageLast = last;
        romData   = {24'h0, thr};
        sawNext = 0; sawBreak = 0; sawDone = 0; face = 0; idx = '0; cyc = 0;
        for (int i = 1; i <= 8; i++) begin
            tick();
            if (nextStage || breakOut) begin
                sawNext  = nextStage;
                sawBreak = breakOut;
                sawDone  = doneOut;
                face     = faceOut;
                idx      = stageIdx;
                cyc      = i;
                break;
            end
        end
        stageVal  = 1'b0;
        stageLast = 1'b0;
        total++;
        if (cyc == 0) begin
            bad++;
            $display("[TB] FAIL stage_timeout: got no decision, want one within 8 cycles");
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #1;
        total++;
        if ({waitOut, nextStage, breakOut, doneOut, faceOut, stageIdx, errOut} !== {1'b1, 4'b0, 5'd0, 1'b0}) begin
            bad++;
            $display("[TB] FAIL reset_outputs: got wait=%b ns=%b brk=%b done=%b face=%b idx=%0d err=%b, want 1 0 0 0 0 0 0",
                     waitOut, nextStage, breakOut, doneOut, faceOut, stageIdx, errOut);
        end
        tick();
        rst = 1'b0;
    endtask

    task automatic test_stage_pass();
        logic n, b, d, f;
        logic [4:0] idx;
        int cyc;
        do_reset();
        pulse_start();
        total++;
        if (waitOut !== 1'b0) begin bad++; $display("[TB] FAIL run_wait: got %b want 0", waitOut); end
        load_stage_a();
        run_stage(24'd12, 1'b0, n, b, d, f, idx, cyc);
        total++;
        if ({n, b} !== 2'b10) begin bad++; $display("[TB] FAIL pass_pulses: got ns=%b brk=%b want 1 0", n, b); end
        total++;
        if (idx !== 5'd1) begin bad++; $display("[TB] FAIL pass_idx: got %0d want 1", idx); end
        total++;
        if (cyc != 1) begin bad++; $display("[TB] FAIL pass_latency: got %0d want 1", cyc); end
        tick();
        total++;
        if (nextStage !== 1'b0) begin bad++; $display("[TB] FAIL pass_single_pulse: got %b want 0", nextStage); end
        // A cleared accumulator gives 15 again, which fails a threshold of 16.
        load_stage_a();
        run_stage(24'd16, 1'b0, n, b, d, f, idx, cyc);
        total++;
        if ({n, b, f, idx} !== {1'b0, 1'b1, 1'b0, 5'd1}) begin
            bad++;
            $display("[TB] FAIL acc_cleared: got ns=%b brk=%b face=%b idx=%0d want 0 1 0 1", n, b, f, idx);
        end
    endtask

    task automatic test_stage_fail();
        logic n, b, d, f;
        logic [4:0] idx;
        int cyc;
        do_reset();
        pulse_start();
        load_stage_a();
        run_stage(24'd20, 1'b0, n, b, d, f, idx, cyc);
        total++;
        if ({n, b, d} !== 3'b011) begin bad++; $display("[TB] FAIL fail_pulses: got ns=%b brk=%b done=%b want 0 1 1", n, b, d); end
        total++;
        if ({f, idx} !== {1'b0, 5'd0}) begin bad++; $display("[TB] FAIL fail_result: got face=%b idx=%0d want 0 0", f, idx); end
        tick();
        total++;
        if ({breakOut, waitOut} !== 2'b01) begin bad++; $display("[TB] FAIL fail_after: got brk=%b wait=%b want 0 1", breakOut, waitOut); end
    endtask

    task automatic test_last_stage();
        logic n, b, d, f;
        logic [4:0] idx;
        int cyc;
        do_reset();
        pulse_start();
        for (int s = 0; s < 2; s++) begin
            load_stage_a();
            run_stage(24'd12, 1'b0, n, b, d, f, idx, cyc);
            total++;
            if ({n, idx} !== {1'b1, 5'(s + 1)}) begin bad++; $display("[TB] FAIL last_prestage%0d: got ns=%b idx=%0d want 1 %0d", s, n, idx, s + 1); end
            tick();
        end
        load_stage_a();
        run_stage(24'd15, 1'b1, n, b, d, f, idx, cyc);
        total++;
        if ({n, b, d, f, idx} !== {1'b0, 1'b1, 1'b1, 1'b1, 5'd2}) begin
            bad++;
            $display("[TB] FAIL last_decision: got ns=%b brk=%b done=%b face=%b idx=%0d want 0 1 1 1 2", n, b, d, f, idx);
        end
        for (int i = 0; i < 3; i++) tick();
        total++;
        if ({faceOut, doneOut} !== 2'b10) begin bad++; $display("[TB] FAIL face_held: got face=%b done=%b want 1 0", faceOut, doneOut); end
        pulse_start();
        total++;
        if ({faceOut, stageIdx} !== {1'b0, 5'd0}) begin bad++; $display("[TB] FAIL start_clears: got face=%b idx=%0d want 0 0", faceOut, stageIdx); end
    endtask

    task automatic test_backpressure();
        logic n, b, d, f;
        logic [4:0] idx;
        int cyc;
        int issued = 0, delivered = 0, consumed = 0, pendIdx = 0;
        logic pend = 0, waitPrev, waitNow, sawWait = 0, errSeen = 0;
        do_reset();
        pulse_start();
        waitPrev = waitOut;
        // Sequencer reacts to wait one cycle late; feature unit silent for 8 cycles.
        for (int c = 0; c < 60; c++) begin
            waitNow = waitOut;
            if (waitNow) sawWait = 1;
            if (errOut) errSeen = 1;
            if (pend) begin
                romData = {16'(10 * pendIdx), 16'hFF9C, 16'(1 << pendIdx)};
                delivered++;
            end
            pend = 0;
            if (issued < 6 && !waitPrev) begin
                romVal = 1'b1; pend = 1; pendIdx = issued; issued++;
            end else begin
                romVal = 1'b0;
            end
            if (c >= 8 && consumed < delivered) begin
                featVal = 1'b1; featIn = 16'(10 * consumed); consumed++;
            end else begin
                featVal = 1'b0;
            end
            waitPrev = waitNow;
            tick();
            if (consumed == 6 && !pend) break;
        end
        romVal = 1'b0;
        featVal = 1'b0;
        total++;
        if (consumed != 6) begin bad++; $display("[TB] FAIL bp_consumed: got %0d want 6", consumed); end
        total++;
        if (sawWait !== 1'b1) begin bad++; $display("[TB] FAIL bp_wait_seen: got %b want 1", sawWait); end
        total++;
        if ((errSeen | errOut) !== 1'b0) begin bad++; $display("[TB] FAIL bp_no_err: got %b want 0", errSeen | errOut); end
        // In-order scoring picks every right leaf: 1+2+4+8+16+32 = 63.
        run_stage(24'd63, 1'b1, n, b, d, f, idx, cyc);
        total++;
        if ({b, f} !== 2'b11) begin bad++; $display("[TB] FAIL bp_order_sum: got brk=%b face=%b want 1 1", b, f); end
    endtask

    task automatic test_saturation();
        logic n, b, d, f;
        logic [4:0] idx;
        int cyc;
        do_reset();
        pulse_start();
        for (int i = 0; i < 4; i++) send_node(48'h0000_0000_7FFF);
        for (int i = 0; i < 4; i++) send_feat(16'sd0);
        // 16-bit sum saturates at 32767 (a wrap would give -4 and fail).
        run_stage(24'h007FFF, 1'b1, n, b, d, f, idx, cyc);
        total++;
        if (faceOut16 !== 1'b1) begin bad++; $display("[TB] FAIL sat16_face: got %b want 1", faceOut16); end
        total++;
        if (faceOut !== 1'b1) begin bad++; $display("[TB] FAIL sat24_face: got %b want 1", faceOut); end
    endtask

    task automatic test_protocol_errors();
        do_reset();
        pulse_start();
        featVal = 1'b1; featIn = 16'sd3;
        tick();
        featVal = 1'b0;
        total++;
        if (errOut !== 1'b1) begin bad++; $display("[TB] FAIL err_underflow: got %b want 1", errOut); end
        tick(); tick();
        total++;
        if (errOut !== 1'b1) begin bad++; $display("[TB] FAIL err_sticky: got %b want 1", errOut); end
        do_reset();
        total++;
        if (errOut !== 1'b0) begin bad++; $display("[TB] FAIL err_reset_clear: got %b want 0", errOut); end
        pulse_start();
        for (int c = 0; c < 6; c++) begin
            romVal = (c < 5);
            if (c >= 1) romData = NODE_A;
            tick();
            if (c == 4) begin
                total++;
                if (errOut !== 1'b0) begin bad++; $display("[TB] FAIL err_full_ok: got %b want 0", errOut); end
            end
        end
        total++;
        if (errOut !== 1'b1) begin bad++; $display("[TB] FAIL err_overflow: got %b want 1", errOut); end
        do_reset();
        pulse_start();
        stageVal = 1'b1; romData = 48'h0; romVal = 1'b1;
        tick();
        stageVal = 1'b0; romVal = 1'b0;
        total++;
        if (errOut !== 1'b1) begin bad++; $display("[TB] FAIL err_rom_while_stage: got %b want 1", errOut); end
    endtask

    task automatic test_reset_mid_run();
        logic n, b, d, f;
        logic [4:0] idx;
        int cyc;
        do_reset();
        pulse_start();
        load_stage_a();
        run_stage(24'd12, 1'b0, n, b, d, f, idx, cyc);
        tick();
        send_node(NODE_A);
        romVal = 1'b1;
        #2 rst = 1'b1;
        #1;
        total++;
        if ({waitOut, nextStage, breakOut, doneOut, faceOut, stageIdx, errOut} !== {1'b1, 4'b0, 5'd0, 1'b0}) begin
            bad++;
            $display("[TB] FAIL midrun_reset: got wait=%b ns=%b brk=%b done=%b face=%b idx=%0d err=%b, want 1 0 0 0 0 0 0",
                     waitOut, nextStage, breakOut, doneOut, faceOut, stageIdx, errOut);
        end
        romVal = 1'b0;
        tick();
        rst = 1'b0;
        pulse_start();
        // Emptied buffers let an empty final stage decide at once (0 >= 0).
        run_stage(24'd0, 1'b1, n, b, d, f, idx, cyc);
        total++;
        if ({b, f, idx} !== {1'b1, 1'b1, 5'd0}) begin bad++; $display("[TB] FAIL midrun_flushed: got brk=%b face=%b idx=%0d want 1 1 0", b, f, idx); end
    endtask

    initial begin
        rst = 1'b1; startIn = 0; romVal = 0; romData = '0;
        stageVal = 0; stageLast = 0; featVal = 0; featIn = '0;
        tick();
        test_reset();
        test_stage_pass();
        test_stage_fail();
        test_last_stage();
        test_backpressure();
        test_saturation();
        test_protocol_errors();
        test_reset_mid_run();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
